led_scheduler: RTL and testbench
================================

# led_scheduler

Sequencer and arbiter for the three board LEDs (LED1..LED3) on the icoboard. It generates a background pattern (off, on, blink, bouncing chase) timed by an internal prescaler. It grants a higher-priority flash requester temporary ownership of the LEDs, then resumes the background pattern exactly where it stopped. It sits between the top-level LED pins and any logic that wants to signal through the LEDs.

## Interface

Parameters:
- DIV, 3_000_000, prescaler period in clk cycles per pattern tick (≥2); 250 ms at 12 MHz.
- FLASH_TICKS, 4, flash duration in ticks (≥1).

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  requested pattern: 0 OFF, 1 ON, 2 BLINK, 3 CHASE.
- mode_valid  input  1  mode request is present.
- mode_ready  output  1  mode request is accepted this cycle when high with mode_valid.
- flash_req  input  1  flash request (level).
- flash_pattern  input  3  LED value shown during the flash; bit0 = LED1.
- flash_ack  output  1  one-cycle pulse: flash granted.
- flash_done  output  1  one-cycle pulse: flash finished, LEDs returned.
- LED1, LED2, LED3  output  1 each  registered LED drives, active-high.

## Operation

State machine, two states:
- RUN: the background pattern drives the LEDs.
- FLASH: the latched flash pattern drives the LEDs.

Reset:
- State = RUN, mode = OFF.
- Pattern = 000, chase direction = up.
- Prescaler = 0, flash count = 0.
- LEDs = 000, flash_ack = 0, flash_done = 0.

Prescaler:
- Counter cnt runs 0..DIV-1 and is $clog2(DIV) bits wide.
- A tick occurs when cnt == DIV-1; on that edge cnt wraps to 0.
- cnt is forced to 0 on mode accept, on flash grant and on flash end.

Mode accept:
- mode_ready = (state == RUN) && !flash_req. This is combinational.
- On accept: mode is registered and the pattern loads its initial value.
- Initial values: OFF 000, ON 111, BLINK 111, CHASE 001 with direction up.
- Re-accepting the current mode restarts that pattern.

Pattern advance, applied on each tick in RUN:
- OFF and ON: the pattern holds.
- BLINK: the pattern inverts.
- CHASE: the pattern steps 001→010→100→010→001→… The direction flips at 100 and at 001.

Flash grant:
- Condition: state RUN and flash_req = 1. Flash has priority over mode.
- On grant: flash_pattern is latched, state goes to FLASH and the flash count is cleared.
- The background pattern and chase direction are frozen during the flash.
- Each tick in FLASH increments the flash count.
- On the tick where the flash count == FLASH_TICKS-1, state returns to RUN and the LEDs reload the frozen pattern.
- flash_req is ignored while in FLASH.
- If flash_req is still high after the return, a new grant occurs on the first RUN cycle.

Reset mid-operation:
- Reset always wins, including mid-flash.
- A flash interrupted by reset produces no flash_done.

## Timing

Mode:
- The request is sampled at edge k; LEDs show the initial pattern after edge k, i.e. a latency of 1 cycle.
- The first advance happens DIV cycles after that.

Flash:
- flash_req is sampled at edge j.
- After edge j, the LEDs show flash_pattern and flash_ack is high for exactly one cycle.
- The LEDs hold flash_pattern for exactly FLASH_TICKS×DIV cycles.
- After the end edge, the LEDs show the frozen pattern and flash_done is high for exactly one cycle.
- The next background advance comes DIV cycles after the return.

General:
- A BLINK or CHASE step lasts exactly DIV cycles.
- All outputs except mode_ready are registered.

## Test plan

Use DIV=4 and FLASH_TICKS=2 throughout.
- Reset: hold rst 2 cycles with flash_req=0 -> LEDs 000; mode_ready 1; flash_ack and flash_done 0; LEDs stay 000 for 20 cycles.
- ON then BLINK: accept mode 1 -> LEDs 111 one cycle later and steady; accept mode 2 -> 111 for 4 cycles, 000 for 4 cycles, repeating for 3 periods.
- CHASE: accept mode 3 -> 001,010,100,010,001,010, each held 4 cycles.
- Flash mid-chase: while the chase shows 100 (direction down), pulse flash_req for 1 cycle with flash_pattern=101 -> flash_ack for 1 cycle; LEDs 101 for 8 cycles; flash_done for 1 cycle; LEDs 100 for 4 cycles, then 010.
- Simultaneous requests: flash_req=1 and mode_valid=1 with mode=1 in the same cycle -> mode_ready 0, flash granted; mode accepted on the first RUN cycle after flash_done; LEDs 111 one cycle later.
- Reset mid-flash: assert rst 4 cycles into a flash -> LEDs 000, mode OFF, state RUN; flash_done never pulses.

Source files
------------

// File: rtl/led_scheduler.sv
// led_scheduler: background LED pattern generator (off/on/blink/chase) with a
// prescaled tick, plus a priority flash requester that temporarily owns the
// LEDs and then hands them back to the frozen background pattern.
module led_scheduler #(
    parameter int DIV         = 3_000_000,
    parameter int FLASH_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       flash_req,
    input  logic [2:0] flash_pattern,
    output logic       flash_ack,
    output logic       flash_done,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3
);

    localparam int CW = $clog2(DIV);
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_CHASE = 2'd3;

    typedef enum logic {S_RUN, S_FLASH} state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_mode,  w_mode;
    logic [2:0]    r_pat,   w_pat;
    logic          r_dir,   w_dir;    // chase direction: 0 = up (toward LED3), 1 = down
    logic [CW-1:0] r_cnt,   w_cnt;
    logic [FW-1:0] r_fcnt,  w_fcnt;
    logic [2:0]    r_fpat,  w_fpat;
    logic [2:0]    r_led,   w_led;
    logic          r_ack,   w_ack;
    logic          r_done,  w_done;

    logic          w_tick;
    logic [2:0]    w_chase;
    logic          w_chase_dir;
    logic [2:0]    w_adv;

    assign w_tick     = (r_cnt == CW'(DIV - 1));
    assign mode_ready = (r_state == S_RUN) && !flash_req;

    // One chase step; direction flips as the walker lands on either end.
    assign w_chase     = r_dir ? (r_pat >> 1) : (r_pat << 1);
    assign w_chase_dir = (w_chase == 3'b100) ? 1'b1 :
                         (w_chase == 3'b001) ? 1'b0 : r_dir;

    // Pattern value after one tick in the current mode.
    always_comb begin
        w_adv = r_pat;
        case (r_mode)
            M_BLINK: w_adv = ~r_pat;
            M_CHASE: w_adv = w_chase;
            default: w_adv = r_pat;
        endcase
    end

    // Next-state and output logic; flash wins over mode, mode wins over tick.
    always_comb begin
        w_state = r_state;
        w_mode  = r_mode;
        w_pat   = r_pat;
        w_dir   = r_dir;
        w_cnt   = w_tick ? CW'(0) : r_cnt + 1'b1;
        w_fcnt  = r_fcnt;
        w_fpat  = r_fpat;
        w_led   = r_led;
        w_ack   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (flash_req) begin
                    // Background pattern and direction stay frozen in r_pat/r_dir.
                    w_state = S_FLASH;
                    w_fpat  = flash_pattern;
                    w_fcnt  = '0;
                    w_cnt   = '0;
                    w_led   = flash_pattern;
                    w_ack   = 1'b1;
                end else if (mode_valid) begin
                    w_mode = mode;
                    w_cnt  = '0;
                    w_dir  = 1'b0;
                    case (mode)
                        M_OFF:   w_pat = 3'b000;
                        M_ON:    w_pat = 3'b111;
                        M_BLINK: w_pat = 3'b111;
                        default: w_pat = 3'b001;
                    endcase
                    w_led = w_pat;
                end else if (w_tick) begin
                    w_pat = w_adv;
                    if (r_mode == M_CHASE)
                        w_dir = w_chase_dir;
                    w_led = w_adv;
                end
            end
            default: begin
                if (w_tick) begin
                    if (r_fcnt == FW'(FLASH_TICKS - 1)) begin
                        w_state = S_RUN;
                        w_led   = r_pat;
                        w_done  = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_fcnt = r_fcnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // State register; reset returns everything to RUN/OFF with LEDs dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_mode  <= M_OFF;
            r_pat   <= 3'b000;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_fpat  <= 3'b000;
            r_led   <= 3'b000;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_mode  <= w_mode;
            r_pat   <= w_pat;
            r_dir   <= w_dir;
            r_cnt   <= w_cnt;
            r_fcnt  <= w_fcnt;
            r_fpat  <= w_fpat;
            r_led   <= w_led;
            r_ack   <= w_ack;
            r_done  <= w_done;
        end
    end

    assign flash_ack  = r_ack;
    assign flash_done = r_done;
    assign LED1       = r_led[0];
    assign LED2       = r_led[1];
    assign LED3       = r_led[2];

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: directed scenarios followed by random traffic,
// all compared cycle by cycle against a step-count reference model.
module tb_led_scheduler;

    localparam int DIV = 4;
    localparam int FT  = 2;

    logic       gclk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_ready;
    logic       flash_req;
    logic [2:0] flash_pattern;
    logic       flash_ack;
    logic       flash_done;
    logic       LED1, LED2, LED3;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pattern is a function of mode and number of completed steps.
    int         m_mode = 0;
    int         m_k    = 0;
    int         m_c    = 0;
    bit         m_fl   = 0;
    int         m_rem  = 0;
    logic [2:0] m_fpat = 3'b000;
    bit         m_ack  = 0;
    bit         m_done = 0;

    always #5 gclk = ~gclk;

    led_scheduler #(.DIV(DIV), .FLASH_TICKS(FT)) dut (
        .clk(gclk), .rst(rst), .mode(mode), .mode_valid(mode_valid),
        .mode_ready(mode_ready), .flash_req(flash_req),
        .flash_pattern(flash_pattern), .flash_ack(flash_ack),
        .flash_done(flash_done), .LED1(LED1), .LED2(LED2), .LED3(LED3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] bg_pat(input int md, input int k);
        logic [2:0] seq [4];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b010;
        case (md)
            0:       return 3'b000;
            1:       return 3'b111;
            2:       return (k % 2 == 0) ? 3'b111 : 3'b000;
            default: return seq[k % 4];
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit mv, input int md, input bit fr, input logic [2:0] fp);
        m_ack  = 0;
        m_done = 0;
        if (r) begin
            m_mode = 0; m_k = 0; m_c = 0; m_fl = 0; m_rem = 0;
        end else if (m_fl) begin
            m_rem--;
            if (m_rem == 0) begin
                m_fl = 0; m_done = 1; m_c = 0;
            end
        end else if (fr) begin
            m_fl = 1; m_rem = FT * DIV; m_fpat = fp; m_ack = 1; m_c = 0;
        end else if (mv) begin
            m_mode = md; m_k = 0; m_c = 0;
        end else begin
            m_c++;
            if (m_c == DIV) begin
                m_c = 0; m_k++;
            end
        end
    endtask

    // One clock: drive at negedge, check ready, clock, then check registered outputs.
    task automatic cyc(input bit r, input bit mv, input int md, input bit fr, input logic [2:0] fp);
        rst = r; mode_valid = mv; mode = md[1:0]; flash_req = fr; flash_pattern = fp;
        #1;
        chk("mode_ready", {31'd0, mode_ready}, {31'd0, !m_fl && !fr});
        @(posedge gclk);
        model_edge(r, mv, md, fr, fp);
        @(negedge gclk);
        chk("leds", {29'd0, LED3, LED2, LED1}, {29'd0, m_fl ? m_fpat : bg_pat(m_mode, m_k)});
        chk("flash_ack", {31'd0, flash_ack}, {31'd0, m_ack});
        chk("flash_done", {31'd0, flash_done}, {31'd0, m_done});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'b000);
    endtask

    initial begin
        rst = 1; mode = 0; mode_valid = 0; flash_req = 0; flash_pattern = 0;
        @(negedge gclk);
        // Reset and quiet idle
        cyc(1, 0, 0, 0, 3'b000);
        cyc(1, 0, 0, 0, 3'b000);
        idle(20);
        // ON, then BLINK for 3 periods
        cyc(0, 1, 1, 0, 3'b000);
        idle(6);
        cyc(0, 1, 2, 0, 3'b000);
        idle(24);
        // CHASE; after 8 cycles it shows 100, then flash 101 mid-chase
        cyc(0, 1, 3, 0, 3'b000);
        idle(8);
        cyc(0, 0, 0, 1, 3'b101);
        idle(16);
        // Flash and mode requested together; mode held until accepted
        cyc(0, 1, 1, 1, 3'b011);
        for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 3'b000);
        idle(4);
        // Flash held high across return forces an immediate re-grant
        cyc(0, 1, 3, 0, 3'b000);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 3'b110);
        idle(12);
        // Reset four cycles into a flash
        cyc(0, 0, 0, 1, 3'b010);
        idle(3);
        cyc(1, 0, 0, 0, 3'b000);
        idle(12);
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, mv, fr;
            r  = ($urandom_range(0, 199) == 0);
            mv = ($urandom_range(0, 19) == 0);
            fr = ($urandom_range(0, 29) == 0);
            cyc(r, mv, $urandom_range(0, 3), fr, 3'($urandom_range(0, 7)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
